// File: rtl/intc_pkg.sv
// intc_pkg: shared types and constants for the CPU-side interrupt sequencer
package intc_pkg;
  localparam int INTC_XLEN = 32;
  localparam int unsigned INTC_NULL_VEC = 0;
  typedef enum logic [1:0] {RUN, ENTER, ISR, EXIT} intc_state_e;
endpackage

// File: rtl/intc_cpu_seq_if.sv
// intc_cpu_seq_if: controller/CPU-facing signals of the interrupt sequencer
//   master: drives IRQ, isr_addr, retire, pc_next, mret, mie_we, mie_wdata
//   slave : the sequencer, drives IACK, redirect, redirect_pc, stall, epc,
//           mie, in_isr, spurious, irq_lat
interface intc_cpu_seq_if #(parameter int XLEN = intc_pkg::INTC_XLEN, parameter int LAT_W = 16);
  logic IRQ;
  logic [XLEN-1:0] isr_addr;
  logic retire;
  logic [XLEN-1:0] pc_next;
  logic mret;
  logic mie_we;
  logic mie_wdata;
  logic IACK;
  logic redirect;
  logic [XLEN-1:0] redirect_pc;
  logic stall;
  logic [XLEN-1:0] epc;
  logic mie;
  logic in_isr;
  logic spurious;
  logic [LAT_W-1:0] irq_lat;
  modport master (
    output IRQ, isr_addr, retire, pc_next, mret, mie_we, mie_wdata,
    input IACK, redirect, redirect_pc, stall, epc, mie, in_isr, spurious, irq_lat
  );
  modport slave (
    input IRQ, isr_addr, retire, pc_next, mret, mie_we, mie_wdata,
    output IACK, redirect, redirect_pc, stall, epc, mie, in_isr, spurious, irq_lat
  );
endinterface

// File: rtl/intc_lat_cnt.sv
// intc_lat_cnt: saturating request-latency counter with capture on acceptance
//   clk, rst (sync, active-low); i_req = IRQ & mie; i_run = sequencer in RUN;
//   i_cap = acceptance strobe; o_lat = count+1 captured at acceptance
module intc_lat_cnt #(parameter int LAT_W = 16) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req,
  input  logic             i_run,
  input  logic             i_cap,
  output logic [LAT_W-1:0] o_lat
);
  logic [LAT_W-1:0] r_cnt, r_lat, w_inc;
  assign w_inc = &r_cnt ? r_cnt : r_cnt + LAT_W'(1);
  assign o_lat = r_lat;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
      r_lat <= '0;
    end else begin
      r_cnt <= i_req ? w_inc : (i_run ? '0 : r_cnt);
      if (i_cap) r_lat <= w_inc;
    end
  end
endmodule

// File: rtl/intc_cpu_seq.sv
// intc_cpu_seq: interrupt entry/exit sequencer (PC redirect, mie/mpie, epc)
//   clk, rst (sync, active-low); bus: intc_cpu_seq_if.slave
//   Optional latency counter enabled by macro INTC_LAT_CNT_EN.
module intc_cpu_seq import intc_pkg::*; #(
  parameter int XLEN  = INTC_XLEN,
  parameter int LAT_W = 16
) (
  input logic           clk,
  input logic           rst,
  intc_cpu_seq_if.slave bus
);
  intc_state_e r_state, w_state_nxt;
  logic [XLEN-1:0] r_epc, r_vec, w_epc_nxt, w_vec_nxt, w_rpc;
  logic r_mie, r_mpie, r_spur, w_mie_nxt, w_mpie_nxt, w_spur_nxt;
  logic w_accept, w_vec_ok, w_ret, w_iack, w_redirect, w_stall, w_in_isr;
  logic [LAT_W-1:0] w_irq_lat;
  assign w_accept = (r_state == RUN) & bus.IRQ & r_mie & bus.retire;
  assign w_vec_ok = r_vec != XLEN'(INTC_NULL_VEC);
  assign w_ret    = bus.retire & bus.mret;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= RUN;
      r_epc   <= '0;
      r_vec   <= '0;
      r_mie   <= 1'b0;
      r_mpie  <= 1'b0;
      r_spur  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_epc   <= w_epc_nxt;
      r_vec   <= w_vec_nxt;
      r_mie   <= w_mie_nxt;
      r_mpie  <= w_mpie_nxt;
      r_spur  <= w_spur_nxt;
    end
  end
  // Hardware updates of mie take priority: software writes only land in RUN
  // or ISR cycles that are not themselves transitioning.
  always_comb begin
    w_state_nxt = r_state;
    w_epc_nxt   = r_epc;
    w_vec_nxt   = r_vec;
    w_mie_nxt   = r_mie;
    w_mpie_nxt  = r_mpie;
    w_spur_nxt  = r_spur;
    w_iack      = 1'b0;
    w_redirect  = 1'b0;
    w_rpc       = '0;
    w_stall     = 1'b0;
    w_in_isr    = 1'b0;
    case (r_state)
      RUN: begin
        if (w_accept) begin
          w_state_nxt = ENTER;
          w_epc_nxt   = bus.pc_next;
          w_vec_nxt   = bus.isr_addr;
          w_mpie_nxt  = r_mie;
          w_mie_nxt   = 1'b0;
        end else if (bus.mie_we) w_mie_nxt = bus.mie_wdata;
      end
      ENTER: begin
        w_iack  = 1'b1;
        w_stall = 1'b1;
        if (w_vec_ok) begin
          w_redirect  = 1'b1;
          w_rpc       = r_vec;
          w_state_nxt = ISR;
        end else begin
          w_spur_nxt  = 1'b1;
          w_mie_nxt   = r_mpie;
          w_state_nxt = RUN;
        end
      end
      ISR: begin
        w_in_isr = 1'b1;
        if (w_ret) w_state_nxt = EXIT;
        else if (bus.mie_we) w_mie_nxt = bus.mie_wdata;
      end
      EXIT: begin
        w_redirect  = 1'b1;
        w_rpc       = r_epc;
        w_stall     = 1'b1;
        w_mie_nxt   = r_mpie;
        w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
  end
`ifdef INTC_LAT_CNT_EN
  intc_lat_cnt #(.LAT_W(LAT_W)) u_lat (
    .clk   (clk),
    .rst   (rst),
    .i_req (bus.IRQ & r_mie),
    .i_run (r_state == RUN),
    .i_cap (w_accept),
    .o_lat (w_irq_lat)
  );
`else
  assign w_irq_lat = '0;
`endif
  assign bus.IACK        = w_iack;
  assign bus.redirect    = w_redirect;
  assign bus.redirect_pc = w_rpc;
  assign bus.stall       = w_stall;
  assign bus.epc         = r_epc;
  assign bus.mie         = r_mie;
  assign bus.in_isr      = w_in_isr;
  assign bus.spurious    = r_spur;
  assign bus.irq_lat     = w_irq_lat;
endmodule
